// File: rtl/multiplier_pipe_nxn.sv
// Three-stage pipelined WIDTH x WIDTH multiplier built from four half-width partial products,
// with a valid/ready handshake, per-operation signed/unsigned mode and an opaque tag sideband.
module multiplier_pipe_nxn #(
  parameter int WIDTH     = 16,
  parameter int SIGNED_EN = 1,
  parameter int TAG_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  localparam int HALF   = WIDTH / 2;
  localparam int PROD_W = 2 * WIDTH;
  localparam int MID_W  = WIDTH + 1;

  logic en;

  // Stage 1: operand magnitudes and sign bits
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_mag_a_q, s1_mag_a_d;
  logic [WIDTH-1:0] s1_mag_b_q, s1_mag_b_d;
  logic             s1_sa_q, s1_sa_d;
  logic             s1_sb_q, s1_sb_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  // Stage 2: partial products and result sign
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_hh_q, s2_hh_d;
  logic [WIDTH-1:0] s2_hl_q, s2_hl_d;
  logic [WIDTH-1:0] s2_lh_q, s2_lh_d;
  logic [WIDTH-1:0] s2_ll_q, s2_ll_d;
  logic             s2_neg_q, s2_neg_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  // Stage 3: final product, drives the outputs directly
  logic              s3_valid_q, s3_valid_d;
  logic [PROD_W-1:0] s3_p_q, s3_p_d;
  logic [TAG_W-1:0]  s3_tag_q, s3_tag_d;

  logic              signed_op;
  logic [MID_W-1:0]  mid_sum;
  logic [PROD_W-1:0] mag_sum;

  // The whole pipe advances together; a stalled output freezes every stage, bubbles included.
  assign en       = !s3_valid_q || out_ready;
  assign in_ready = en;

  assign signed_op = (SIGNED_EN != 0) && is_signed;

  // NOTE: every _d gets a full default (hold) before any conditional update, so no latches are inferred.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mag_a_d = s1_mag_a_q;
    s1_mag_b_d = s1_mag_b_q;
    s1_sa_d    = s1_sa_q;
    s1_sb_d    = s1_sb_q;
    s1_tag_d   = s1_tag_q;
    if (en) begin
      s1_valid_d = in_valid;
      s1_sa_d    = signed_op && a[WIDTH-1];
      s1_sb_d    = signed_op && b[WIDTH-1];
      // Magnitude of the most negative value is 2^(WIDTH-1), which still fits unsigned.
      s1_mag_a_d = s1_sa_d ? -a : a;
      s1_mag_b_d = s1_sb_d ? -b : b;
      s1_tag_d   = in_tag;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_hh_d    = s2_hh_q;
    s2_hl_d    = s2_hl_q;
    s2_lh_d    = s2_lh_q;
    s2_ll_d    = s2_ll_q;
    s2_neg_d   = s2_neg_q;
    s2_tag_d   = s2_tag_q;
    if (en) begin
      s2_valid_d = s1_valid_q;
      s2_hh_d    = WIDTH'(s1_mag_a_q[WIDTH-1:HALF]) * WIDTH'(s1_mag_b_q[WIDTH-1:HALF]);
      s2_hl_d    = WIDTH'(s1_mag_a_q[WIDTH-1:HALF]) * WIDTH'(s1_mag_b_q[HALF-1:0]);
      s2_lh_d    = WIDTH'(s1_mag_a_q[HALF-1:0])     * WIDTH'(s1_mag_b_q[WIDTH-1:HALF]);
      s2_ll_d    = WIDTH'(s1_mag_a_q[HALF-1:0])     * WIDTH'(s1_mag_b_q[HALF-1:0]);
      s2_neg_d   = s1_sa_q ^ s1_sb_q;
      s2_tag_d   = s1_tag_q;
    end
  end

  // The magnitude product is at most 2^(2*WIDTH-2) (signed) or (2^WIDTH-1)^2 (unsigned),
  // so the sum is exact at 2*WIDTH bits; only the middle term needs its own carry bit.
  always_comb begin
    mid_sum = MID_W'(s2_hl_q) + MID_W'(s2_lh_q);
    mag_sum = (PROD_W'(s2_hh_q) << WIDTH) + (PROD_W'(mid_sum) << HALF) + PROD_W'(s2_ll_q);
  end

  always_comb begin
    s3_valid_d = s3_valid_q;
    s3_p_d     = s3_p_q;
    s3_tag_d   = s3_tag_q;
    if (en) begin
      s3_valid_d = s2_valid_q;
      // p keeps the last real result across bubbles rather than exposing stale stage data.
      if (s2_valid_q) begin
        s3_p_d   = s2_neg_q ? -mag_sum : mag_sum;
        s3_tag_d = s2_tag_q;
      end
    end
  end

  // NOTE: data registers are reset as well as the valid bits, so p and out_tag read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mag_a_q <= '0;
      s1_mag_b_q <= '0;
      s1_sa_q    <= 1'b0;
      s1_sb_q    <= 1'b0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_hh_q    <= '0;
      s2_hl_q    <= '0;
      s2_lh_q    <= '0;
      s2_ll_q    <= '0;
      s2_neg_q   <= 1'b0;
      s2_tag_q   <= '0;
      s3_valid_q <= 1'b0;
      s3_p_q     <= '0;
      s3_tag_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples the pre-edge value of its predecessor.
      s1_valid_q <= s1_valid_d;
      s1_mag_a_q <= s1_mag_a_d;
      s1_mag_b_q <= s1_mag_b_d;
      s1_sa_q    <= s1_sa_d;
      s1_sb_q    <= s1_sb_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_hh_q    <= s2_hh_d;
      s2_hl_q    <= s2_hl_d;
      s2_lh_q    <= s2_lh_d;
      s2_ll_q    <= s2_ll_d;
      s2_neg_q   <= s2_neg_d;
      s2_tag_q   <= s2_tag_d;
      s3_valid_q <= s3_valid_d;
      s3_p_q     <= s3_p_d;
      s3_tag_q   <= s3_tag_d;
    end
  end

  assign out_valid = s3_valid_q;
  assign p         = s3_p_q;
  assign out_tag   = s3_tag_q;
  assign busy      = s1_valid_q || s2_valid_q || s3_valid_q;

endmodule

// File: tb/tb_multiplier_pipe_nxn.sv
// Bench for multiplier_pipe_nxn: three configurations (16-bit signed-capable, 8-bit, 16-bit unsigned-only)
// share one stimulus stream and are checked every cycle against an arithmetic reference.
module tb_multiplier_pipe_nxn;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        is_signed = 1'b0;
  logic [3:0]  in_tag = '0;
  logic        out_ready = 1'b1;

  logic        ir0, ir1, ir2;
  logic        ov0, ov1, ov2;
  logic        busy0, busy1, busy2;
  logic [31:0] p16, p16u;
  logic [15:0] p8;
  logic [3:0]  tag0, tag1, tag2;

  int n_checks = 0;
  int n_errors = 0;
  int n_out = 0;

  always #5 clk = ~clk;

  multiplier_pipe_nxn #(.WIDTH(16), .SIGNED_EN(1), .TAG_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .a(a), .b(b),
    .is_signed(is_signed), .in_tag(in_tag), .out_valid(ov0), .out_ready(out_ready),
    .p(p16), .out_tag(tag0), .busy(busy0));

  multiplier_pipe_nxn #(.WIDTH(8), .SIGNED_EN(1), .TAG_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .a(a[7:0]), .b(b[7:0]),
    .is_signed(is_signed), .in_tag(in_tag), .out_valid(ov1), .out_ready(out_ready),
    .p(p8), .out_tag(tag1), .busy(busy1));

  multiplier_pipe_nxn #(.WIDTH(16), .SIGNED_EN(0), .TAG_W(4)) dut16u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .a(a), .b(b),
    .is_signed(is_signed), .in_tag(in_tag), .out_valid(ov2), .out_ready(out_ready),
    .p(p16u), .out_tag(tag2), .busy(busy2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: interpret the low w bits as signed or unsigned integers and multiply.
  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y,
                                          input logic s, input int w);
    longint xv, yv, prod;
    xv = longint'(x) & ((longint'(1) << w) - 1);
    yv = longint'(y) & ((longint'(1) << w) - 1);
    if (s && xv >= (longint'(1) << (w - 1))) xv = xv - (longint'(1) << w);
    if (s && yv >= (longint'(1) << (w - 1))) yv = yv - (longint'(1) << w);
    prod = xv * yv;
    prod = prod & ((longint'(1) << (2 * w)) - 1);
    return prod[31:0];
  endfunction

  typedef struct packed {
    logic        v;
    logic [31:0] p16;
    logic [15:0] p8;
    logic [31:0] p16u;
    logic [3:0]  tag;
  } slot_t;

  // Model: three slots that all advance when the output is free or taken; slot 2 is the output.
  slot_t pipe [3];
  logic  en_m, busy_m;

  always @(negedge clk) begin
    if (!rst_n) for (int i = 0; i < 3; i++) pipe[i] = '0;
    en_m   = !pipe[2].v || out_ready;
    busy_m = pipe[0].v || pipe[1].v || pipe[2].v;
    check("in_ready16", {31'b0, ir0}, {31'b0, en_m});
    check("in_ready8", {31'b0, ir1}, {31'b0, en_m});
    check("in_ready16u", {31'b0, ir2}, {31'b0, en_m});
    check("busy16", {31'b0, busy0}, {31'b0, busy_m});
    check("busy8", {31'b0, busy1}, {31'b0, busy_m});
    check("busy16u", {31'b0, busy2}, {31'b0, busy_m});
    check("out_valid16", {31'b0, ov0}, {31'b0, pipe[2].v});
    check("out_valid8", {31'b0, ov1}, {31'b0, pipe[2].v});
    check("out_valid16u", {31'b0, ov2}, {31'b0, pipe[2].v});
    check("p16", p16, pipe[2].p16);
    check("p8", {16'b0, p8}, {16'b0, pipe[2].p8});
    check("p16u", p16u, pipe[2].p16u);
    check("tag16", {28'b0, tag0}, {28'b0, pipe[2].tag});
    check("tag8", {28'b0, tag1}, {28'b0, pipe[2].tag});
    check("tag16u", {28'b0, tag2}, {28'b0, pipe[2].tag});
    if (rst_n && en_m) begin
      if (pipe[2].v) n_out++;
      if (pipe[1].v) pipe[2] = pipe[1];
      else           pipe[2].v = 1'b0;
      pipe[1]   = pipe[0];
      pipe[0].v = in_valid;
      if (in_valid) begin
        pipe[0].p16  = ref_mul(a, b, is_signed, 16);
        pipe[0].p8   = ref_mul(a, b, is_signed, 8) & 32'hFFFF;
        pipe[0].p16u = ref_mul(a, b, 1'b0, 16);
        pipe[0].tag  = in_tag;
      end
    end
  end

  // Present one beat from posedge+1 and hold it until a handshake edge; returns at that edge +1.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                      input logic [3:0] tt);
    bit acc;
    int guard;
    a = ta; b = tb_v; is_signed = ts; in_tag = tt; in_valid = 1'b1;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = ir0;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    check("send_accepted", {31'b0, acc}, 32'd1);
  endtask

  task automatic single(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                        input logic [3:0] tt, input logic [31:0] e16, input logic [15:0] e8,
                        input logic [31:0] e16u);
    int n;
    send(ta, tb_v, ts, tt);
    n = 1;
    while (!ov0 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, 3);
    check("lit_p16", p16, e16);
    check("lit_p8", {16'b0, p8}, {16'b0, e8});
    check("lit_p16u", p16u, e16u);
    check("lit_tag", {28'b0, tag0}, {28'b0, tt});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (busy0 && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain_idle", {31'b0, busy0}, 32'd0);
  endtask

  initial begin
    int     base;
    time    t0;
    logic [3:0] tag;
    bit     done;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed literals: unsigned max, signed extremes, mixed sign, 8-bit corner values.
    single(16'hFFFF, 16'hFFFF, 1'b0, 4'h5, 32'hFFFE0001, 16'hFE01, 32'hFFFE0001);
    single(16'h8000, 16'h8000, 1'b1, 4'h1, 32'h40000000, 16'h0000, 32'h40000000);
    single(16'hFFFF, 16'h0001, 1'b1, 4'h2, 32'hFFFFFFFF, 16'hFFFF, 32'h0000FFFF);
    single(16'h8000, 16'h0000, 1'b1, 4'h3, 32'h00000000, 16'h0000, 32'h00000000);
    single(16'h8080, 16'h8080, 1'b1, 4'h4, 32'h3F804000, 16'h4000, 32'h40804000);
    single(16'h0003, 16'hFFFB, 1'b1, 4'h6, 32'hFFFFFFF1, 16'hFFF1, 32'h0002FFF1);
    single(16'h0080, 16'h0080, 1'b1, 4'h7, 32'h00004000, 16'h4000, 32'h00004000);

    // Back-to-back stream at full throughput.
    base = n_out;
    tag  = 4'h0;
    t0   = $time;
    for (int i = 0; i < 200; i++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), tag);
      tag = tag + 4'h1;
    end
    check("stream_cycles", 32'(($time - t0) / 10), 32'd200);
    drain();
    check("stream_count", n_out - base, 200);

    // Backpressure: three beats fill the pipe, then the output stalls for six cycles.
    out_ready = 1'b0;
    send(16'h1234, 16'h0010, 1'b0, 4'hA);
    send(16'h0002, 16'h8001, 1'b1, 4'hB);
    send(16'h00FF, 16'h0100, 1'b0, 4'hC);
    check("stall_ov", {31'b0, ov0}, 32'd1);
    repeat (6) begin
      @(posedge clk);
      #1;
      check("stall_in_ready", {31'b0, ir0}, 32'd0);
      check("stall_p", p16, 32'h00012340);
      check("stall_tag", {28'b0, tag0}, 32'hA);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rel_p1", p16, 32'hFFFF0002);
    check("rel_tag1", {28'b0, tag0}, 32'hB);
    @(posedge clk);
    #1;
    check("rel_p2", p16, 32'h0000FF00);
    check("rel_tag2", {28'b0, tag0}, 32'hC);
    drain();

    // Asynchronous reset with three operations in flight.
    send(16'h1111, 16'h2222, 1'b0, 4'h1);
    send(16'hF00F, 16'h0F0F, 1'b1, 4'h2);
    send(16'h7FFF, 16'h7FFF, 1'b1, 4'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ov", {31'b0, ov0}, 32'd0);
    check("arst_busy", {31'b0, busy0}, 32'd0);
    check("arst_p16", p16, 32'd0);
    check("arst_p8", {16'b0, p8}, 32'd0);
    check("arst_ov8", {31'b0, ov1}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = n_out;
    repeat (8) @(posedge clk);
    #1;
    check("arst_no_stale", n_out - base, 0);

    // Random backpressure while streaming.
    done = 1'b0;
    base = n_out;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 4'(i));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #2;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", n_out - base, 60);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
